// File: rtl/conv_pkg.sv
// conv_pkg: shared helpers for the streaming KxK convolution.
//   clog2      - ceiling log2 usable in constant expressions
//   acc_width  - adder-tree accumulator width for a given WD/WW/K
//   latency    - cycles from window-completing pixel to o_valid
//   saturate   - clamp a wide signed value into an ow-bit signed range
package conv_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int acc_width(input int wd, input int ww, input int k);
    return wd + ww + 1 + clog2(k * k);
  endfunction

  function automatic int latency(input int k);
    return 2 + clog2(k * k);
  endfunction

  localparam int ACC_W_DEFAULT = acc_width(8, 8, 5);
  localparam int LAT_DEFAULT   = latency(5);

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: ROWS full image rows of history, kept as one shift chain
// that advances on accepted pixels only. A pixel delayed by n*IMG_W accepted
// pixels is the pixel n rows above at the same column.
//   i_sclk  clock
//   i_en    accepted pixel strobe
//   i_pix   incoming pixel
//   o_col   ROWS+1 pixels of the current column; slot 0 = oldest row,
//           slot ROWS = i_pix itself
module conv_line_buffer #(
  parameter int ROWS  = 4,
  parameter int IMG_W = 28,
  parameter int WD    = 8
) (
  input  logic                   i_sclk,
  input  logic                   i_en,
  input  logic [WD-1:0]          i_pix,
  output logic [(ROWS+1)*WD-1:0] o_col
);

  localparam int DEPTH = ROWS * IMG_W;

  logic [WD-1:0] sr_q [DEPTH];

  // Pixel storage only; contents are overwritten before they are ever used
  // after a new frame starts, so no reset is needed.
  always_ff @(posedge i_sclk) begin
    if (i_en) begin
      sr_q[0] <= i_pix;
      for (int n = 1; n < DEPTH; n++) sr_q[n] <= sr_q[n-1];
    end
  end

  always_comb begin
    o_col[ROWS*WD +: WD] = i_pix;
    for (int m = 0; m < ROWS; m++)
      o_col[m*WD +: WD] = sr_q[(ROWS-m)*IMG_W-1];
  end

endmodule

// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: streaming KxK convolution over a raster image.
// Ports:
//   i_sclk, i_rstn          clock, synchronous active-low reset
//   i_vsync                 frame start: clears counters and in-flight tags
//   i_valid, i_tdata        accepted unsigned pixel
//   i_W_en/i_W_addr/i_Weight signed weight write (row-major, addr=i*K+j)
//   i_Bias                  signed bias, sampled at the output stage
//   o_valid, o_tdata        saturated signed result (held while o_valid=0)
//   o_eol, o_eof            last output of row / of frame
// Optional build macro: CONV_KXK_RELU_EN forces negative results to 0.
module conv_kxk_stream
  import conv_pkg::*;
#(
  parameter int K      = 5,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int WD     = 8,
  parameter int WW     = 8,
  parameter int OW     = 8,
  parameter int SHIFT  = 0,
  parameter int STRIDE = 1
) (
  input  logic                     i_sclk,
  input  logic                     i_rstn,
  input  logic                     i_vsync,
  input  logic                     i_valid,
  input  logic [WD-1:0]            i_tdata,
  input  logic                     i_W_en,
  input  logic [$clog2(K*K)-1:0]   i_W_addr,
  input  logic [WW-1:0]            i_Weight,
  input  logic [WW-1:0]            i_Bias,
  output logic                     o_valid,
  output logic [OW-1:0]            o_tdata,
  output logic                     o_eol,
  output logic                     o_eof
);

  localparam int KK   = K * K;
  localparam int L    = clog2(KK);
  localparam int NP   = 1 << L;
  localparam int PW   = WD + WW + 1;
  localparam int ACC  = acc_width(WD, WW, K);
  localparam int CW   = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
  localparam int RW   = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
  // Last column / row at which a window is emitted.
  localparam int LCOL = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;
  localparam int LROW = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;

  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic signed [WW-1:0] w_q [KK];
  logic [WD-1:0]        win_q [KK];
  logic                 wv_q, weol_q, weof_q;
  logic                 tv_q   [L+1];
  logic                 teol_q [L+1];
  logic                 teof_q [L+1];
  logic signed [ACC-1:0] lvl_q [L+1][NP];
  logic                 o_valid_q, o_eol_q, o_eof_q;
  logic [OW-1:0]        o_data_q;

  logic                 accept;
  logic [K*WD-1:0]      col_c;
  logic                 at_emit, at_eol, at_eof;
  logic signed [PW-1:0] prod_c [KK];
  logic signed [63:0]   tot_c;
  logic signed [OW-1:0] res_c;

  assign accept = i_rstn & i_valid & ~i_vsync;

  conv_line_buffer #(
    .ROWS  (K - 1),
    .IMG_W (IMG_W),
    .WD    (WD)
  ) u_lbuf (
    .i_sclk (i_sclk),
    .i_en   (accept),
    .i_pix  (i_tdata),
    .o_col  (col_c)
  );

  // Window-emission decision for the pixel at (row_q, col_q).
  always_comb begin
    at_emit = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1) &&
              (((int'(row_q) - (K - 1)) % STRIDE) == 0) &&
              (((int'(col_q) - (K - 1)) % STRIDE) == 0);
    at_eol  = (int'(col_q) == LCOL);
    at_eof  = at_eol && (int'(row_q) == LROW);
  end

  // Pixel zero-extended to a signed operand before multiplying.
  always_comb begin
    for (int n = 0; n < KK; n++)
      prod_c[n] = PW'($signed({1'b0, win_q[n]})) * PW'(w_q[n]);
  end

  // Output stage: bias, arithmetic shift, saturation.
  always_comb begin
    tot_c = (64'(lvl_q[L][0]) + 64'($signed(i_Bias))) >>> SHIFT;
    res_c = OW'(saturate(tot_c, OW));
`ifdef CONV_KXK_RELU_EN
    if (res_c[OW-1]) res_c = '0;
`endif
  end

  // Datapath registers: window shift, products, adder tree. No reset needed;
  // validity is carried by the tag pipeline.
  always_ff @(posedge i_sclk) begin
    if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_q[i*K+j] <= win_q[i*K+j+1];
        win_q[i*K+K-1] <= col_c[i*WD +: WD];
      end
    end
    for (int n = 0; n < KK; n++) lvl_q[0][n] <= ACC'(prod_c[n]);
    for (int n = KK; n < NP; n++) lvl_q[0][n] <= '0;
    for (int l = 1; l <= L; l++)
      for (int n = 0; n < (NP >> l); n++)
        lvl_q[l][n] <= lvl_q[l-1][2*n] + lvl_q[l-1][2*n+1];
  end

  // Control: counters, weights, valid/marker tags, output registers.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      col_q     <= '0;
      row_q     <= '0;
      for (int n = 0; n < KK; n++) w_q[n] <= '0;
      wv_q      <= 1'b0;
      weol_q    <= 1'b0;
      weof_q    <= 1'b0;
      for (int l = 0; l <= L; l++) begin
        tv_q[l]   <= 1'b0;
        teol_q[l] <= 1'b0;
        teof_q[l] <= 1'b0;
      end
      o_valid_q <= 1'b0;
      o_eol_q   <= 1'b0;
      o_eof_q   <= 1'b0;
      o_data_q  <= '0;
    end else begin
      if (i_W_en && (int'(i_W_addr) < KK)) w_q[i_W_addr] <= $signed(i_Weight);

      if (i_vsync) begin
        col_q     <= '0;
        row_q     <= '0;
        wv_q      <= 1'b0;
        weol_q    <= 1'b0;
        weof_q    <= 1'b0;
        for (int l = 0; l <= L; l++) begin
          tv_q[l]   <= 1'b0;
          teol_q[l] <= 1'b0;
          teof_q[l] <= 1'b0;
        end
        o_valid_q <= 1'b0;
        o_eol_q   <= 1'b0;
        o_eof_q   <= 1'b0;
      end else begin
        if (i_valid) begin
          if (col_q == CW'(IMG_W - 1)) begin
            col_q <= '0;
            row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        wv_q      <= i_valid & at_emit;
        weol_q    <= i_valid & at_emit & at_eol;
        weof_q    <= i_valid & at_emit & at_eof;
        tv_q[0]   <= wv_q;
        teol_q[0] <= weol_q;
        teof_q[0] <= weof_q;
        for (int l = 1; l <= L; l++) begin
          tv_q[l]   <= tv_q[l-1];
          teol_q[l] <= teol_q[l-1];
          teof_q[l] <= teof_q[l-1];
        end
        o_valid_q <= tv_q[L];
        o_eol_q   <= tv_q[L] & teol_q[L];
        o_eof_q   <= tv_q[L] & teof_q[L];
        if (tv_q[L]) o_data_q <= res_c;
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o_tdata = o_data_q;
  assign o_eol   = o_eol_q;
  assign o_eof   = o_eof_q;

endmodule

// File: tb/tb_conv_kxk_stream.sv
module tb_conv_kxk_stream;

  localparam int K = 3, W = 8, H = 8, LAT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, vsync, valid, wen;
  logic [7:0] tdata, wdat, bias;
  logic [3:0] waddr;
  logic       ov [3];
  logic [7:0] od [3];
  logic       oe [3];
  logic       of [3];

  // d0: stride 1 shift 0, d1: stride 2, d2: shift 1
  conv_kxk_stream #(.K(3), .IMG_W(8), .IMG_H(8), .WD(8), .WW(8), .OW(8),
                    .SHIFT(0), .STRIDE(1)) dut_a (
    .i_sclk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_valid(valid),
    .i_tdata(tdata), .i_W_en(wen), .i_W_addr(waddr), .i_Weight(wdat),
    .i_Bias(bias), .o_valid(ov[0]), .o_tdata(od[0]), .o_eol(oe[0]), .o_eof(of[0]));

  conv_kxk_stream #(.K(3), .IMG_W(8), .IMG_H(8), .WD(8), .WW(8), .OW(8),
                    .SHIFT(0), .STRIDE(2)) dut_b (
    .i_sclk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_valid(valid),
    .i_tdata(tdata), .i_W_en(wen), .i_W_addr(waddr), .i_Weight(wdat),
    .i_Bias(bias), .o_valid(ov[1]), .o_tdata(od[1]), .o_eol(oe[1]), .o_eof(of[1]));

  conv_kxk_stream #(.K(3), .IMG_W(8), .IMG_H(8), .WD(8), .WW(8), .OW(8),
                    .SHIFT(1), .STRIDE(1)) dut_c (
    .i_sclk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_valid(valid),
    .i_tdata(tdata), .i_W_en(wen), .i_W_addr(waddr), .i_Weight(wdat),
    .i_Bias(bias), .o_valid(ov[2]), .o_tdata(od[2]), .o_eol(oe[2]), .o_eof(of[2]));

  typedef struct {
    int     id;
    int     val;
    bit     eol;
    bit     eof;
    longint cyc;
  } rec_t;

  rec_t   exp_q[$];
  rec_t   obs_q[$];
  int     img [H][W];
  int     wt [9];
  int     bias_v;
  longint acc_cyc [H][W];
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d] === 1'b1) begin
        rec_t r;
        r.id  = d;
        r.val = int'($signed(od[d]));
        r.eol = oe[d];
        r.eof = of[d];
        r.cyc = cyc;
        obs_q.push_back(r);
      end
    end
  end

  task automatic chk(input string tag, input longint o, input longint e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_w(input int a, input int v);
    logic [7:0] b;
    logic [3:0] ab;
    b  = v[7:0];
    ab = a[3:0];
    wen = 1'b1; waddr = ab; wdat = b;
    step(1);
    wen = 1'b0;
    if (a < 9) wt[a] = v;
  endtask

  task automatic all_w(input int v);
    for (int n = 0; n < 9; n++) write_w(n, v);
  endtask

  task automatic set_bias(input int b);
    bias_v = b;
    bias   = b[7:0];
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? 1 : (mode == 1) ? 8*r + c :
                    (mode == 2) ? 255 : int'($urandom_range(0, 255));
  endtask

  // mode: 0 continuous, 1 valid every third cycle, 2 random gaps
  task automatic drive_frame(input int mode, input bit do_vs, input int last_idx);
    if (do_vs) begin
      vsync = 1'b1; valid = 1'b0;
      step(1);
      vsync = 1'b0;
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r*W + c <= last_idx) begin
          int g;
          g = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
          repeat (g) begin
            valid = 1'b0; tdata = 8'($urandom);
            step(1);
          end
          valid = 1'b1; tdata = 8'(img[r][c]);
          step(1);
          acc_cyc[r][c] = cyc;
        end
      end
    end
    valid = 1'b0;
  endtask

  function automatic int ref_val(input int r0, input int c0, input int shift);
    longint s;
    s = bias_v;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(wt[i*K+j]) * img[r0+i][c0+j];
    s = s >>> shift;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef CONV_KXK_RELU_EN
    if (s < 0) s = 0;
`endif
    return int'(s);
  endfunction

  task automatic expect_frame();
    for (int d = 0; d < 3; d++) begin
      int st, sh, lr, lc;
      st = (d == 1) ? 2 : 1;
      sh = (d == 2) ? 1 : 0;
      lr = ((H - K) / st) * st;
      lc = ((W - K) / st) * st;
      for (int r0 = 0; r0 <= H - K; r0 += st) begin
        for (int c0 = 0; c0 <= W - K; c0 += st) begin
          rec_t e;
          e.id  = d;
          e.val = ref_val(r0, c0, sh);
          e.eol = (c0 == lc);
          e.eof = (c0 == lc) && (r0 == lr);
          e.cyc = acc_cyc[r0+K-1][c0+K-1] + LAT;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  function automatic int count_obs(input int id);
    int n;
    n = 0;
    foreach (obs_q[k]) if (obs_q[k].id == id) n++;
    return n;
  endfunction

  function automatic int first_obs(input int id);
    foreach (obs_q[k]) if (obs_q[k].id == id) return k;
    return -1;
  endfunction

  function automatic int last_obs(input int id);
    int k;
    k = -1;
    foreach (obs_q[n]) if (obs_q[n].id == id) k = n;
    return k;
  endfunction

  task automatic check_frame(input string tag);
    for (int d = 0; d < 3; d++) begin
      int ei[$];
      int oi[$];
      int n;
      foreach (exp_q[k]) if (exp_q[k].id == d) ei.push_back(k);
      foreach (obs_q[k]) if (obs_q[k].id == d) oi.push_back(k);
      chk($sformatf("%s_d%0d_count", tag, d), oi.size(), ei.size());
      n = (oi.size() < ei.size()) ? oi.size() : ei.size();
      for (int k = 0; k < n; k++) begin
        rec_t o, e;
        o = obs_q[oi[k]];
        e = exp_q[ei[k]];
        chk($sformatf("%s_d%0d_%0d_val", tag, d, k), o.val, e.val);
        chk($sformatf("%s_d%0d_%0d_eol", tag, d, k), o.eol, e.eol);
        chk($sformatf("%s_d%0d_%0d_eof", tag, d, k), o.eof, e.eof);
        chk($sformatf("%s_d%0d_%0d_cyc", tag, d, k), o.cyc, e.cyc);
      end
      if (ei.size() > 0)
        chk($sformatf("%s_d%0d_hold", tag, d), int'($signed(od[d])),
            exp_q[ei[ei.size()-1]].val);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    longint vcyc;
    int     k, stale;

    rstn = 1'b0; vsync = 1'b0; valid = 1'b0; wen = 1'b0;
    tdata = '0; wdat = '0; waddr = '0; bias = '0; bias_v = 0;
    for (int n = 0; n < 9; n++) wt[n] = 0;
    step(3);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_d%0d_valid", d), ov[d], 0);
      chk($sformatf("reset_d%0d_tdata", d), od[d], 0);
      chk($sformatf("reset_d%0d_eol", d), oe[d], 0);
      chk($sformatf("reset_d%0d_eof", d), of[d], 0);
    end
    rstn = 1'b1;
    step(2);

    // 1: all ones
    all_w(1); set_bias(0); fill_img(0);
    drive_frame(0, 1'b1, H*W - 1);
    expect_frame();
    step(LAT + 4);
    chk("s1_count_a", count_obs(0), 36);
    chk("s1_count_b", count_obs(1), 9);
    k = first_obs(0);
    chk("s1_first_lat", (k >= 0) ? obs_q[k].cyc - acc_cyc[2][2] : -1, 6);
    chk("s1_first_val", (k >= 0) ? obs_q[k].val : -999, 9);
    check_frame("s1");

    // 2: centre tap only, ramp image
    all_w(0); write_w(4, 1); fill_img(1);
    drive_frame(0, 1'b1, H*W - 1);
    expect_frame();
    step(LAT + 4);
    k = first_obs(0);
    chk("s2_first", (k >= 0) ? obs_q[k].val : -999, 9);
    k = last_obs(0);
    chk("s2_last", (k >= 0) ? obs_q[k].val : -999, 54);
    check_frame("s2");

    // 3: positive and negative saturation
    all_w(127); fill_img(2);
    drive_frame(0, 1'b1, H*W - 1);
    expect_frame();
    step(LAT + 4);
    k = first_obs(0);
    chk("s3_pos", (k >= 0) ? obs_q[k].val : -999, 127);
    check_frame("s3p");
    all_w(-128);
    drive_frame(0, 1'b1, H*W - 1);
    expect_frame();
    step(LAT + 4);
    k = first_obs(0);
`ifdef CONV_KXK_RELU_EN
    chk("s3_neg", (k >= 0) ? obs_q[k].val : -999, 0);
`else
    chk("s3_neg", (k >= 0) ? obs_q[k].val : -999, -128);
`endif
    check_frame("s3n");

    // 4: valid every third cycle
    all_w(1); fill_img(0);
    drive_frame(1, 1'b1, H*W - 1);
    expect_frame();
    step(LAT + 4);
    check_frame("s4");

    // 5: random weights, bias, pixels and gaps; out-of-range write ignored
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 9; n++) write_w(n, int'($urandom_range(0, 255)) - 128);
      write_w(12, 55);
      set_bias(int'($urandom_range(0, 255)) - 128);
      fill_img(3);
      drive_frame(2, 1'b1, H*W - 1);
      expect_frame();
      step(LAT + 4);
      check_frame($sformatf("s5r%0d", f));
    end

    // 6: vsync mid-frame after pixel (4,5), with a dropped pixel
    all_w(1); set_bias(0); fill_img(0);
    drive_frame(0, 1'b1, 4*W + 5);
    vsync = 1'b1; valid = 1'b1; tdata = 8'd99;
    step(1);
    vcyc = cyc;
    vsync = 1'b0; valid = 1'b0;
    step(LAT + 3);
    stale = 0;
    foreach (obs_q[n]) if (obs_q[n].cyc >= vcyc) stale++;
    chk("s6_stale", stale, 0);
    obs_q.delete();
    set_bias(-10);
    drive_frame(0, 1'b0, H*W - 1);
    expect_frame();
    step(LAT + 4);
    k = first_obs(2);
    chk("s6_shift_bias", (k >= 0) ? obs_q[k].val : -999, -1);
    check_frame("s6");

    // 7: reset mid-frame clears weights and in-flight outputs
    drive_frame(0, 1'b1, 5*W + 2);
    rstn = 1'b0;
    step(2);
    for (int d = 0; d < 3; d++) chk($sformatf("s7_rst_d%0d_valid", d), ov[d], 0);
    rstn = 1'b1;
    obs_q.delete();
    for (int n = 0; n < 9; n++) wt[n] = 0;
    set_bias(5);
    drive_frame(0, 1'b0, H*W - 1);
    expect_frame();
    step(LAT + 4);
    k = first_obs(0);
    chk("s7_bias_only", (k >= 0) ? obs_q[k].val : -999, 5);
    check_frame("s7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
